// File: rtl/frv_pipeline_writeback_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | frv_pipeline_writeback_pkg                                           |
// | Shared LSU micro-op encoding, FU indices and trap causes.            |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package frv_pipeline_writeback_pkg;

  // Bit positions inside s4_uop for LSU operations; [1:0] carry the width.
  localparam int LSU_LOAD   = 3;
  localparam int LSU_STORE  = 4;
  localparam int LSU_SIGNED = 2;

  localparam logic [1:0] LSU_BYTE = 2'b01;
  localparam logic [1:0] LSU_HALF = 2'b10;
  localparam logic [1:0] LSU_WORD = 2'b11;

  localparam int P_FU_ALU = 0;
  localparam int P_FU_LSU = 2;

  localparam logic [5:0] TRAP_LDACCESS = 6'd5;
  localparam logic [5:0] TRAP_STACCESS = 6'd7;

  function automatic logic [1:0] lsu_width(input logic [4:0] uop);
    return uop[1:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/frv_wb_load_align.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | frv_wb_load_align                                                    |
// | Shifts load data to bit 0, extracts byte/half/word and extends.      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module frv_wb_load_align #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rdata,
  input  logic [1:0]      offset,
  input  logic            lsu_byte,
  input  logic            lsu_half,
  input  logic            lsu_word,
  input  logic            lsu_signed,
  output logic [XLEN-1:0] wdata
);

  logic [XLEN-1:0] w_shift;

  assign w_shift = rdata >> {offset, 3'b000};

  always_comb begin
    wdata = '0;
    if (lsu_byte) begin
      wdata = {{(XLEN-8){lsu_signed & w_shift[7]}}, w_shift[7:0]};
    end else if (lsu_half) begin
      wdata = {{(XLEN-16){lsu_signed & w_shift[15]}}, w_shift[15:0]};
    end else if (lsu_word) begin
      wdata = w_shift;
    end
  end

endmodule
`default_nettype wire

// File: rtl/frv_pipeline_writeback.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | frv_pipeline_writeback                                               |
// | Writeback stage: retires s4, collects dmem responses, raises traps.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module frv_pipeline_writeback
  import frv_pipeline_writeback_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            g_clk,
  input  logic            g_resetn,
  input  logic            flush,
  input  logic [4:0]      s4_rd,
  input  logic [XLEN-1:0] s4_opr_a,
  input  logic [XLEN-1:0] s4_opr_b,
  input  logic [4:0]      s4_uop,
  input  logic [4:0]      s4_fu,
  input  logic            s4_trap,
  input  logic            s4_valid,
  output logic            s4_busy,
  input  logic            dmem_issue,
  input  logic            dmem_recv,
  input  logic            dmem_error,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            dmem_ack,
  output logic            gpr_wen,
  output logic [4:0]      gpr_rd,
  output logic [XLEN-1:0] gpr_wdata,
  output logic            trap_valid,
  output logic [5:0]      trap_cause,
  output logic            retire,
  output logic [4:0]      fwd_s4_rd,
  output logic [XLEN-1:0] fwd_s4_wdata,
  output logic            fwd_s4_load
);

  logic            r_buf_full;
  logic            r_buf_err;
  logic [XLEN-1:0] r_buf_data;
  logic [1:0]      r_out_cnt;
  logic [1:0]      r_drop_cnt;

  logic            w_lsu;
  logic            w_load;
  logic            w_live;
  logic            w_avail;
  logic            w_rsp_err;
  logic [XLEN-1:0] w_rsp_data;
  logic [XLEN-1:0] w_ld_data;
  logic            w_lsu_ret;
  logic            w_drop_rsp;
  logic            w_capture;
  logic [2:0]      w_out_sum;
  logic [2:0]      w_out_dec;
  logic [2:0]      w_flush_sub;
  logic [1:0]      w_out_nxt;
  logic [1:0]      w_flush_drop;
  logic [1:0]      w_width;
  logic            w_unused_bits;

  assign w_width    = lsu_width(s4_uop);
  assign w_lsu      = s4_valid && !s4_trap && s4_fu[P_FU_LSU];
  assign w_load     = s4_uop[LSU_LOAD];
  assign w_live     = dmem_recv && (r_drop_cnt == 2'd0);
  assign w_avail    = r_buf_full || w_live;
  assign w_rsp_data = r_buf_full ? r_buf_data : dmem_rdata;
  assign w_rsp_err  = r_buf_full ? r_buf_err  : dmem_error;
  assign w_lsu_ret  = w_lsu && w_avail && !flush;
  assign w_drop_rsp = dmem_recv && (r_drop_cnt != 2'd0);

  // A live response is parked when nobody wants it, or when the buffer is
  // being drained by s4 in the same cycle (buffer always wins the consumer).
  assign w_capture  = w_live && (w_lsu ? r_buf_full : !r_buf_full);

  // Outstanding count includes a parked response until it is consumed.
  assign w_out_sum  = {1'b0, r_out_cnt} + {2'b00, dmem_issue};
  assign w_out_dec  = {2'b00, w_lsu_ret || w_drop_rsp};
  assign w_out_nxt  = (w_out_sum < w_out_dec) ? 2'd0 :
                      ((w_out_sum - w_out_dec) > 3'd2) ? 2'd2 :
                      2'(w_out_sum - w_out_dec);

  assign w_flush_sub  = {2'b00, dmem_recv} + {2'b00, r_buf_full};
  assign w_flush_drop = (w_out_sum < w_flush_sub) ? 2'd0 :
                        ((w_out_sum - w_flush_sub) > 3'd2) ? 2'd2 :
                        2'(w_out_sum - w_flush_sub);

  assign w_unused_bits = ^{s4_opr_b[XLEN-1:2], s4_fu[4:3], s4_fu[1:0], s4_uop[LSU_STORE]};

  frv_wb_load_align #(
    .XLEN (XLEN)
  ) u_load_align (
    .rdata      (w_rsp_data),
    .offset     (s4_opr_b[1:0]),
    .lsu_byte   (w_width == LSU_BYTE),
    .lsu_half   (w_width == LSU_HALF),
    .lsu_word   (w_width == LSU_WORD),
    .lsu_signed (s4_uop[LSU_SIGNED]),
    .wdata      (w_ld_data)
  );

  always_comb begin
    s4_busy     = 1'b0;
    dmem_ack    = 1'b0;
    fwd_s4_load = 1'b0;
    gpr_wen     = 1'b0;
    gpr_rd      = 5'd0;
    gpr_wdata   = '0;
    trap_valid  = 1'b0;
    trap_cause  = 6'd0;
    retire      = 1'b0;
    if (g_resetn) begin
      s4_busy     = w_lsu && !w_avail;
      dmem_ack    = dmem_recv && !(r_buf_full && !w_lsu);
      fwd_s4_load = w_lsu && w_load && !w_avail;
      gpr_rd      = s4_rd;
      gpr_wdata   = w_lsu ? w_ld_data : s4_opr_a;
      if (s4_valid && !flush) begin
        if (!w_lsu) begin
          retire = 1'b1;
          if (s4_trap) begin
            trap_valid = 1'b1;
            trap_cause = {1'b0, s4_rd};
          end else begin
            gpr_wen = (s4_rd != 5'd0);
          end
        end else if (w_avail) begin
          retire = 1'b1;
          if (w_rsp_err) begin
            trap_valid = 1'b1;
            trap_cause = w_load ? TRAP_LDACCESS : TRAP_STACCESS;
          end else begin
            gpr_wen = w_load && (s4_rd != 5'd0);
          end
        end
      end
    end
  end

  assign fwd_s4_rd    = gpr_rd;
  assign fwd_s4_wdata = gpr_wdata;

  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      r_buf_full <= 1'b0;
      r_buf_err  <= 1'b0;
      r_buf_data <= '0;
      r_out_cnt  <= 2'd0;
      r_drop_cnt <= 2'd0;
    end else if (flush) begin
      r_buf_full <= 1'b0;
      r_drop_cnt <= w_flush_drop;
      r_out_cnt  <= w_flush_drop;
    end else begin
      if (w_drop_rsp) begin
        r_drop_cnt <= r_drop_cnt - 2'd1;
      end
      if (w_capture) begin
        r_buf_full <= 1'b1;
        r_buf_data <= dmem_rdata;
        r_buf_err  <= dmem_error;
      end else if (w_lsu_ret && r_buf_full) begin
        r_buf_full <= 1'b0;
      end
      r_out_cnt <= w_out_nxt;
    end
  end

  a_no_overrun : assert property (@(posedge g_clk) disable iff (!g_resetn)
    !(w_live && r_buf_full && !w_lsu && !flush));

  a_out_sat : assert property (@(posedge g_clk) disable iff (!g_resetn)
    flush || ((w_out_sum < w_out_dec) || ((w_out_sum - w_out_dec) <= 3'd2)));

endmodule
`default_nettype wire

// File: tb/tb_frv_pipeline_writeback.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_frv_pipeline_writeback                                            |
// | Directed bench for the writeback stage.                              |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_frv_pipeline_writeback;
  import frv_pipeline_writeback_pkg::*;

  localparam logic [4:0] FU_ALU  = 5'b00001;
  localparam logic [4:0] FU_LSU  = 5'b00100;
  localparam logic [4:0] UOP_LB  = 5'b01101;
  localparam logic [4:0] UOP_LHU = 5'b01010;
  localparam logic [4:0] UOP_LW  = 5'b01011;
  localparam logic [4:0] UOP_SW  = 5'b10011;

  logic        g_clk = 1'b0;
  logic        g_resetn;
  logic        flush;
  logic [4:0]  s4_rd;
  logic [31:0] s4_opr_a;
  logic [31:0] s4_opr_b;
  logic [4:0]  s4_uop;
  logic [4:0]  s4_fu;
  logic        s4_trap;
  logic        s4_valid;
  logic        s4_busy;
  logic        dmem_issue;
  logic        dmem_recv;
  logic        dmem_error;
  logic [31:0] dmem_rdata;
  logic        dmem_ack;
  logic        gpr_wen;
  logic [4:0]  gpr_rd;
  logic [31:0] gpr_wdata;
  logic        trap_valid;
  logic [5:0]  trap_cause;
  logic        retire;
  logic [4:0]  fwd_s4_rd;
  logic [31:0] fwd_s4_wdata;
  logic        fwd_s4_load;

  int n_checks = 0;
  int n_errors = 0;

  always #5 g_clk = ~g_clk;

  frv_pipeline_writeback #(.XLEN(32)) dut (
    .g_clk        (g_clk),
    .g_resetn     (g_resetn),
    .flush        (flush),
    .s4_rd        (s4_rd),
    .s4_opr_a     (s4_opr_a),
    .s4_opr_b     (s4_opr_b),
    .s4_uop       (s4_uop),
    .s4_fu        (s4_fu),
    .s4_trap      (s4_trap),
    .s4_valid     (s4_valid),
    .s4_busy      (s4_busy),
    .dmem_issue   (dmem_issue),
    .dmem_recv    (dmem_recv),
    .dmem_error   (dmem_error),
    .dmem_rdata   (dmem_rdata),
    .dmem_ack     (dmem_ack),
    .gpr_wen      (gpr_wen),
    .gpr_rd       (gpr_rd),
    .gpr_wdata    (gpr_wdata),
    .trap_valid   (trap_valid),
    .trap_cause   (trap_cause),
    .retire       (retire),
    .fwd_s4_rd    (fwd_s4_rd),
    .fwd_s4_wdata (fwd_s4_wdata),
    .fwd_s4_load  (fwd_s4_load)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    flush      = 1'b0;
    s4_rd      = 5'd0;
    s4_opr_a   = 32'd0;
    s4_opr_b   = 32'd0;
    s4_uop     = 5'd0;
    s4_fu      = 5'd0;
    s4_trap    = 1'b0;
    s4_valid   = 1'b0;
    dmem_issue = 1'b0;
    dmem_recv  = 1'b0;
    dmem_error = 1'b0;
    dmem_rdata = 32'd0;
  endtask

  task automatic next();
    @(posedge g_clk);
    #1;
    idle();
  endtask

  task automatic settle();
    @(negedge g_clk);
  endtask

  task automatic alu(input logic [4:0] rd, input logic [31:0] val);
    s4_valid = 1'b1;
    s4_fu    = FU_ALU;
    s4_rd    = rd;
    s4_opr_a = val;
  endtask

  task automatic lsu(input logic [4:0] uop, input logic [31:0] addr, input logic [4:0] rd);
    s4_valid = 1'b1;
    s4_fu    = FU_LSU;
    s4_uop   = uop;
    s4_opr_a = 32'h0000_000F;
    s4_opr_b = addr;
    s4_rd    = rd;
  endtask

  task automatic rsp(input logic [31:0] data, input logic err);
    dmem_recv  = 1'b1;
    dmem_rdata = data;
    dmem_error = err;
  endtask

  initial begin
    idle();
    g_resetn = 1'b0;
    repeat (2) @(posedge g_clk);
    #1;
    // Reset: outputs held low even with live-looking inputs.
    alu(5'd5, 32'h1234);
    rsp(32'h1, 1'b0);
    settle();
    check("rst_wen", {31'd0, gpr_wen}, 32'd0);
    check("rst_retire", {31'd0, retire}, 32'd0);
    check("rst_ack", {31'd0, dmem_ack}, 32'd0);
    check("rst_wdata", gpr_wdata, 32'd0);
    @(posedge g_clk);
    #1;
    g_resetn = 1'b1;
    idle();

    // ALU op retires in the same cycle.
    alu(5'd5, 32'h1234);
    settle();
    check("alu_wen", {31'd0, gpr_wen}, 32'd1);
    check("alu_rd", {27'd0, gpr_rd}, 32'd5);
    check("alu_wdata", gpr_wdata, 32'h1234);
    check("alu_retire", {31'd0, retire}, 32'd1);
    check("alu_busy", {31'd0, s4_busy}, 32'd0);
    check("alu_fwd", fwd_s4_wdata, 32'h1234);
    next();
    alu(5'd0, 32'h77);
    settle();
    check("alu_x0_wen", {31'd0, gpr_wen}, 32'd0);
    check("alu_x0_retire", {31'd0, retire}, 32'd1);

    // LB signed, response one cycle after s4_valid.
    next();
    dmem_issue = 1'b1;
    next();
    lsu(UOP_LB, 32'h101, 5'd7);
    settle();
    check("lb_busy", {31'd0, s4_busy}, 32'd1);
    check("lb_fwd_load", {31'd0, fwd_s4_load}, 32'd1);
    check("lb_wait_retire", {31'd0, retire}, 32'd0);
    next();
    lsu(UOP_LB, 32'h101, 5'd7);
    rsp(32'hA1B2C3D4, 1'b0);
    settle();
    check("lb_busy2", {31'd0, s4_busy}, 32'd0);
    check("lb_retire", {31'd0, retire}, 32'd1);
    check("lb_wen", {31'd0, gpr_wen}, 32'd1);
    check("lb_rd", {27'd0, fwd_s4_rd}, 32'd7);
    check("lb_wdata", gpr_wdata, 32'hFFFFFFC3);
    check("lb_ack", {31'd0, dmem_ack}, 32'd1);

    // LHU, response arrives before the instruction and is buffered.
    next();
    dmem_issue = 1'b1;
    next();
    rsp(32'hA1B2C3D4, 1'b0);
    settle();
    check("buf_ack", {31'd0, dmem_ack}, 32'd1);
    check("buf_retire", {31'd0, retire}, 32'd0);
    next();
    lsu(UOP_LHU, 32'h102, 5'd8);
    dmem_issue = 1'b1;
    settle();
    check("lhu_busy", {31'd0, s4_busy}, 32'd0);
    check("lhu_retire", {31'd0, retire}, 32'd1);
    check("lhu_wdata", gpr_wdata, 32'h0000A1B2);
    check("lhu_fwd_load", {31'd0, fwd_s4_load}, 32'd0);
    next();
    lsu(UOP_LW, 32'h104, 5'd9);
    settle();
    check("buf_cleared_busy", {31'd0, s4_busy}, 32'd1);
    next();
    lsu(UOP_LW, 32'h104, 5'd9);
    rsp(32'h11223344, 1'b0);
    settle();
    check("lw_wdata", gpr_wdata, 32'h11223344);
    check("lw_retire", {31'd0, retire}, 32'd1);

    // Store access fault.
    next();
    dmem_issue = 1'b1;
    next();
    lsu(UOP_SW, 32'h200, 5'd0);
    rsp(32'h0, 1'b1);
    settle();
    check("sw_trap", {31'd0, trap_valid}, 32'd1);
    check("sw_cause", {26'd0, trap_cause}, {26'd0, TRAP_STACCESS});
    check("sw_wen", {31'd0, gpr_wen}, 32'd0);
    check("sw_retire", {31'd0, retire}, 32'd1);

    // Load access fault.
    next();
    dmem_issue = 1'b1;
    next();
    lsu(UOP_LW, 32'h204, 5'd9);
    rsp(32'h12345678, 1'b1);
    settle();
    check("lw_err_trap", {31'd0, trap_valid}, 32'd1);
    check("lw_err_cause", {26'd0, trap_cause}, {26'd0, TRAP_LDACCESS});
    check("lw_err_wen", {31'd0, gpr_wen}, 32'd0);

    // Flush with two outstanding: both responses dropped.
    next();
    dmem_issue = 1'b1;
    next();
    dmem_issue = 1'b1;
    next();
    lsu(UOP_LW, 32'h300, 5'd10);
    flush = 1'b1;
    settle();
    check("flush_retire", {31'd0, retire}, 32'd0);
    check("flush_wen", {31'd0, gpr_wen}, 32'd0);
    next();
    lsu(UOP_LW, 32'h300, 5'd10);
    rsp(32'hDEAD0001, 1'b0);
    settle();
    check("drop1_ack", {31'd0, dmem_ack}, 32'd1);
    check("drop1_retire", {31'd0, retire}, 32'd0);
    check("drop1_busy", {31'd0, s4_busy}, 32'd1);
    next();
    lsu(UOP_LW, 32'h300, 5'd10);
    rsp(32'hBEEF0002, 1'b0);
    settle();
    check("drop2_ack", {31'd0, dmem_ack}, 32'd1);
    check("drop2_retire", {31'd0, retire}, 32'd0);
    next();
    lsu(UOP_LW, 32'h300, 5'd10);
    dmem_issue = 1'b1;
    settle();
    check("post_drop_busy", {31'd0, s4_busy}, 32'd1);
    next();
    lsu(UOP_LW, 32'h300, 5'd10);
    rsp(32'hCAFEF00D, 1'b0);
    settle();
    check("post_drop_retire", {31'd0, retire}, 32'd1);
    check("post_drop_wdata", gpr_wdata, 32'hCAFEF00D);

    // Trapped upstream op: no response needed.
    next();
    lsu(UOP_LW, 32'h0, 5'd2);
    s4_trap = 1'b1;
    settle();
    check("trap_valid", {31'd0, trap_valid}, 32'd1);
    check("trap_cause", {26'd0, trap_cause}, 32'd2);
    check("trap_busy", {31'd0, s4_busy}, 32'd0);
    check("trap_ack", {31'd0, dmem_ack}, 32'd0);
    check("trap_wen", {31'd0, gpr_wen}, 32'd0);
    check("trap_retire", {31'd0, retire}, 32'd1);

    // Reset mid-drain clears the drop counter.
    next();
    dmem_issue = 1'b1;
    next();
    flush = 1'b1;
    next();
    g_resetn = 1'b0;
    next();
    g_resetn = 1'b1;
    dmem_issue = 1'b1;
    next();
    lsu(UOP_LW, 32'h400, 5'd11);
    rsp(32'h00000055, 1'b0);
    settle();
    check("rst_mid_retire", {31'd0, retire}, 32'd1);
    check("rst_mid_wdata", gpr_wdata, 32'h00000055);
    next();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
